// File: rtl/scr_dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scr_dma_pkg
//  Purpose  : Shared types and constants for the scratch-RAM DMA engine.
//             Holds the FSM state enum and the transfer-mode encodings.
//  Revision : 1.0 - initial release
// ============================================================================
package scr_dma_pkg;

    // FSM states. The width and the codes are fixed so the state register
    // has a known encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Transfer mode, sampled together with START.
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage : scr_dma_pkg
`default_nettype wire

// File: rtl/scr_dma_if.sv
`default_nettype none
// ============================================================================
//  Module   : scr_dma_if
//  Purpose  : Bundles the DMA request/status signals and the scratch-RAM
//             port into one interface.
//  Ports    : start/mode/src_addr/dst_addr/len/fill_data/abort - request
//             scr_rdata                - RAM read data (combinational)
//             scr_addr/scr_we/scr_wdata - RAM address / write port
//             busy/done                - status
//  Modports : slave  - the DMA engine
//             master - the requester plus the RAM it drives
//  Revision : 1.0 - initial release
// ============================================================================
interface scr_dma_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
);
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] fill_data;
    logic              abort;
    logic [DATA_W-1:0] scr_rdata;
    logic [ADDR_W-1:0] scr_addr;
    logic              scr_we;
    logic [DATA_W-1:0] scr_wdata;
    logic              busy;
    logic              done;

    modport slave (
        input  start, mode, src_addr, dst_addr, len, fill_data, abort,
        input  scr_rdata,
        output scr_addr, scr_we, scr_wdata, busy, done
    );

    modport master (
        output start, mode, src_addr, dst_addr, len, fill_data, abort,
        output scr_rdata,
        input  scr_addr, scr_we, scr_wdata, busy, done
    );

endinterface : scr_dma_if
`default_nettype wire

// File: rtl/scr_dma.sv
`default_nettype none
// ============================================================================
//  Module   : scr_dma
//  Purpose  : Scratch-RAM DMA engine. Copies LEN words from SRC to DST
//             (one READ cycle then one WRITE cycle per word) or fills LEN
//             words at DST with a constant (one WRITE cycle per word).
//             Ascending order, silent address wrap, single-cycle DONE.
//  Ports    : clk  - clock, all state changes on the rising edge
//             rst  - asynchronous active-high reset
//             bus  - scr_dma_if.slave (request, status and RAM port)
//  Revision : 1.0 - initial release
// ============================================================================
module scr_dma
    import scr_dma_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
) (
    input  wire logic clk,
    input  wire logic rst,
    scr_dma_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_zero = '0;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_mode;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_fill;
    logic [DATA_W-1:0] r_hold;

    logic [ADDR_W-1:0] w_scr_addr;
    logic              w_scr_we;
    logic [DATA_W-1:0] w_scr_wdata;
    logic              w_busy;
    logic              w_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == c_zero) begin
                        w_state_nxt = FIN;
                    end else if (bus.mode == MODE_FILL) begin
                        w_state_nxt = WRITE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ: begin
                w_state_nxt = bus.abort ? FIN : WRITE;
            end
            WRITE: begin
                // r_cnt still holds the count before this word, so a value
                // of one means this is the last word.
                if (bus.abort || (r_cnt == c_one)) begin
                    w_state_nxt = FIN;
                end else if (r_mode == MODE_FILL) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = READ;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state and registers only, so no input has a
    // combinational path to the RAM port.
    // ------------------------------------------------------------------
    always_comb begin
        w_scr_addr  = '0;
        w_scr_we    = 1'b0;
        w_scr_wdata = '0;
        w_busy      = (r_state != IDLE);
        w_done      = (r_state == FIN);
        case (r_state)
            READ: begin
                w_scr_addr = r_src;
            end
            WRITE: begin
                w_scr_addr  = r_dst;
                w_scr_we    = 1'b1;
                w_scr_wdata = (r_mode == MODE_FILL) ? r_fill : r_hold;
            end
            default: begin
                w_scr_addr  = '0;
            end
        endcase
    end

    assign bus.scr_addr  = w_scr_addr;
    assign bus.scr_we    = w_scr_we;
    assign bus.scr_wdata = w_scr_wdata;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;

    // ------------------------------------------------------------------
    // Datapath: operand latch, hold register, pointer/count advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_COPY;
            r_src  <= '0;
            r_dst  <= '0;
            r_cnt  <= '0;
            r_fill <= '0;
            r_hold <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mode <= bus.mode;
                        r_src  <= bus.src_addr;
                        r_dst  <= bus.dst_addr;
                        r_cnt  <= bus.len;
                        r_fill <= bus.fill_data;
                    end
                end
                READ: begin
                    r_hold <= bus.scr_rdata;
                end
                WRITE: begin
                    // Pointers wrap naturally at the address width.
                    r_src <= r_src + c_one;
                    r_dst <= r_dst + c_one;
                    r_cnt <= r_cnt - c_one;
                end
                default: begin
                    r_hold <= r_hold;
                end
            endcase
        end
    end

endmodule : scr_dma
`default_nettype wire

// File: doc/scr_dma.md
SCR_DMA -- requirements
Module: scr_dma

Interface
REQ-001 Parameter ADDR_W, default 8, scratch RAM address width.
REQ-002 Parameter DATA_W, default 10, scratch RAM data width.
REQ-003 Ports: one clock; reset asynchronous, active-high.
  - CLK  in  1  clock; all state changes on rising edge.
  - RST  in  1  asynchronous, active-high reset.
REQ-004 START  in  1  request transfer; sampled only in IDLE.
REQ-005 MODE  in  1  0 = copy, 1 = fill; sampled with START.
REQ-006 SRC_ADDR  in  ADDR_W  copy source base; sampled with START.
REQ-007 DST_ADDR  in  ADDR_W  destination base; sampled with START.
REQ-008 LEN  in  ADDR_W  word count 0..255; sampled with START.
REQ-009 FILL_DATA  in  DATA_W  fill value; sampled with START.
REQ-010 ABORT  in  1  synchronous early termination.
REQ-011 SCR_RDATA  in  DATA_W  scratch RAM DATA_OUT; combinational read of SCR_ADDR.
REQ-012 SCR_ADDR  out  ADDR_W  scratch RAM address.
REQ-013 SCR_WE  out  1  scratch RAM write enable.
REQ-014 SCR_WDATA  out  DATA_W  scratch RAM DATA_IN.
REQ-015 BUSY  out  1  high in any state other than IDLE.
REQ-016 DONE  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE and FIN; encoding SHALL be registered.
REQ-018 Transitions from IDLE on START:
  - START=1 with LEN=0 -> FIN.
  - START=1, MODE=0 -> READ.
  - START=1, MODE=1 -> WRITE.
  - Operands latched into internal registers on the same edge.
REQ-019 READ SHALL drive SCR_ADDR = current source pointer with SCR_WE=0, capture SCR_RDATA into a hold register at the edge, and go to WRITE.
REQ-020 WRITE SHALL drive:
  - SCR_ADDR = current destination pointer.
  - SCR_WE = 1.
  - SCR_WDATA = hold register in copy mode, latched FILL_DATA in fill mode.
REQ-021 On leaving WRITE, both pointers SHALL increment modulo 2^ADDR_W and the remaining count SHALL decrement.
  - Remaining count reaches 0 -> FIN.
  - Otherwise -> READ (copy) or WRITE (fill).
REQ-022 Cycle counts for LEN = N:
  - Copy: 2N cycles in READ/WRITE.
  - Fill: N cycles in WRITE.
  - Then exactly one FIN cycle with DONE=1, then IDLE.
REQ-023 Pointer wrap from 0xFF to 0x00 SHALL be silent, with no error indication.
REQ-024 Copy order SHALL be ascending; overlapping regions with DST > SRC propagate already-written words, and this is the defined behaviour.
REQ-025 START while BUSY=1 SHALL be ignored, with no latching and no queuing.
REQ-026 ABORT=1 in READ or WRITE SHALL force the next state to FIN.
  - A write in a WRITE cycle where ABORT is asserted still occurs, since SCR_WE is already high.
  - ABORT in IDLE or FIN SHALL have no effect.
REQ-027 Simultaneous ABORT and final-word WRITE SHALL go to FIN, producing a single DONE pulse.
REQ-028 SCR_ADDR, SCR_WE and SCR_WDATA SHALL be pure functions of state and registers, with no combinational path from any input.
REQ-029 In IDLE and FIN, outputs SHALL be SCR_WE=0, SCR_ADDR=0 and SCR_WDATA=0.

Reset
REQ-030 RST=1 SHALL immediately, without waiting for CLK, force:
  - state = IDLE.
  - SCR_WE=0, BUSY=0, DONE=0.
  - SCR_ADDR=0, SCR_WDATA=0.
  - All pointers, count and hold register = 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer with no DONE pulse.
REQ-032 After RST deasserts, the first START SHALL be honoured on the next rising edge.

Structure
REQ-033 Package scr_dma_pkg SHALL hold the state enum (IDLE, READ, WRITE, FIN) and the MODE_COPY/MODE_FILL constants.
REQ-034 No sub-module SHALL be used; the FSM and datapath reside in scr_dma.
REQ-035 The block SHALL connect to ScratchRam ports directly; any CPU/DMA bus mux is outside this block.

Verification
REQ-036 Copy test:
  - Stimulus: RAM[0x10..0x12] = 0x3FF, 0x155, 0x2AA; START copy SRC=0x10, DST=0x80, LEN=3.
  - Response: RAM[0x80..0x82] matches the source; BUSY high 7 cycles; DONE high on the 7th cycle only.
REQ-037 Fill with wrap:
  - Stimulus: DST=0xFE, LEN=4, FILL_DATA=0x123.
  - Response: writes at 0xFE, 0xFF, 0x00, 0x01 only; DONE on the 5th cycle.
REQ-038 Zero length:
  - Stimulus: START with LEN=0.
  - Response: next cycle FIN with DONE=1; SCR_WE never asserted.
REQ-039 Busy start:
  - Stimulus: second START with a different DST during a copy of LEN=2.
  - Response: ignored; only the original DST range is written.
REQ-040 Abort:
  - Stimulus: ABORT in the READ cycle of word 2 of a LEN=5 copy.
  - Response: exactly 1 word written; DONE pulse next cycle; then IDLE.
REQ-041 Reset mid-transfer:
  - Stimulus: RST asserted between clock edges during WRITE.
  - Response: SCR_WE and BUSY fall before the next edge; no DONE; the target word is unchanged if RST precedes the edge.
